// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single d_cache port between the memory-stage load/store path
// and the external preload write path. The pipeline normally wins, but a
// starvation counter hands contested cycles to the preload path after
// STARVE_LIM consecutive losses. Grants are combinational. Load data comes
// back registered one cycle later.
module dmem_port_arbiter #(
  parameter int DPW        = 32,
  parameter int STARVE_LIM = 4   // legal range 1..15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  // memory-stage pipeline port
  input  logic           i_cpu_req,
  input  logic           i_cpu_we,
  input  logic [DPW-1:0] i_cpu_addr,
  input  logic [DPW-1:0] i_cpu_wdata,
  output logic [DPW-1:0] o_cpu_rdata,
  output logic           o_cpu_rvalid,
  output logic           o_cpu_err,
  output logic           o_stall_m,
  // external preload port
  input  logic           i_ld_req,
  input  logic [DPW-1:0] i_ld_addr,
  input  logic [DPW-1:0] i_ld_wdata,
  output logic           o_ld_gnt,
  // d_cache port
  output logic [DPW-1:0] o_mem_addr,
  output logic [DPW-1:0] o_mem_wd,
  output logic           o_mem_we,
  input  logic [DPW-1:0] i_mem_rd
);

  localparam logic [3:0] LIM_C = STARVE_LIM[3:0];

  // Owner of the port in the previous cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_LD   = 2'd2
  } owner_e;

  owner_e         r_state;
  owner_e         w_state_next;

  logic [3:0]     r_starve_cnt;
  logic           r_cpu_load;     // previous-cycle pipeline grant was a load
  logic [DPW-1:0] r_cpu_rdata;
  logic           r_cpu_err;

  // request-hold bookkeeping for the stall protocol check
  logic           r_stall_prev;
  logic           r_hold_we;
  logic [DPW-1:0] r_hold_addr;
  logic [DPW-1:0] r_hold_wdata;

  logic           w_misaligned;
  logic           w_cpu_valid;
  logic           w_contested;
  logic           w_starved;
  logic           w_ld_gnt;
  logic           w_cpu_gnt;
  logic           w_stall_m;

  // Request qualification and grant decision. Everything is forced idle
  // while reset is held so nothing touches the cache during reset.
  always_comb begin
    w_misaligned = i_rst_n & i_cpu_req & (i_cpu_addr[1:0] != 2'b00);
    w_cpu_valid  = i_rst_n & i_cpu_req & ~w_misaligned;
    w_contested  = w_cpu_valid & i_ld_req;
    w_starved    = (r_starve_cnt >= LIM_C);
    w_ld_gnt     = i_rst_n & i_ld_req & (~w_cpu_valid | w_starved);
    w_cpu_gnt    = w_cpu_valid & ~w_ld_gnt;
    // a misaligned request is rejected immediately, so it never stalls
    w_stall_m    = w_cpu_valid & ~w_cpu_gnt;
  end

  // Next owner: whoever holds the port this cycle
  always_comb begin
    w_state_next = ST_IDLE;
    if (w_cpu_gnt) begin
      w_state_next = ST_CPU;
    end else if (w_ld_gnt) begin
      w_state_next = ST_LD;
    end
  end

  // Owner state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Starvation counter: counts contested cycles lost by the preload path
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_ld_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (w_contested && (r_starve_cnt != 4'hF)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Load return path: capture cache data on a granted load
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cpu_load  <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_load <= w_cpu_gnt & ~i_cpu_we;
      if (w_cpu_gnt && !i_cpu_we) begin
        r_cpu_rdata <= i_mem_rd;
      end
    end
  end

  // Misalignment error pulse, one cycle after the offending request
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cpu_err <= 1'b0;
    end else begin
      r_cpu_err <= w_misaligned;
    end
  end

  // Cache port mux: idle drives zeros with write disabled
  always_comb begin
    o_mem_addr = '0;
    o_mem_wd   = '0;
    o_mem_we   = 1'b0;
    if (w_cpu_gnt) begin
      o_mem_addr = i_cpu_addr;
      o_mem_wd   = i_cpu_wdata;
      o_mem_we   = i_cpu_we;
    end else if (w_ld_gnt) begin
      o_mem_addr = i_ld_addr;
      o_mem_wd   = i_ld_wdata;
      o_mem_we   = 1'b1;
    end
  end

  // Pipeline-facing outputs; rvalid only follows a cycle the pipeline owned
  // with a load, which also suppresses it for stores and across reset.
  always_comb begin
    o_ld_gnt     = w_ld_gnt;
    o_stall_m    = w_stall_m;
    o_cpu_rdata  = r_cpu_rdata;
    o_cpu_rvalid = (r_state == ST_CPU) & r_cpu_load;
    o_cpu_err    = r_cpu_err;
  end

  // Remember the stalled request so the hold check can compare against it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_prev <= 1'b0;
      r_hold_we    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
    end else begin
      r_stall_prev <= w_stall_m;
      r_hold_we    <= i_cpu_we;
      r_hold_addr  <= i_cpu_addr;
      r_hold_wdata <= i_cpu_wdata;
    end
  end

  // A stalled pipeline request must stay asserted and unchanged
  always_ff @(posedge i_clk) begin
    if (i_rst_n && r_stall_prev) begin
      assert (i_cpu_req && (i_cpu_we == r_hold_we) &&
              (i_cpu_addr == r_hold_addr) && (i_cpu_wdata == r_hold_wdata));
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed scenarios followed by random
// traffic, each cycle compared against a rule-level reference model.
module tb_dmem_port_arbiter;

  localparam int DPW = 32;
  localparam int LIM = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cpu_req, cpu_we;
  logic [DPW-1:0] cpu_addr, cpu_wdata;
  logic [DPW-1:0] cpu_rdata;
  logic           cpu_rvalid, cpu_err, stall_m;
  logic           ld_req;
  logic [DPW-1:0] ld_addr, ld_wdata;
  logic           ld_gnt;
  logic [DPW-1:0] mem_addr, mem_wd, mem_rd;
  logic           mem_we;

  always #5 clk = ~clk;

  // Cache stand-in: combinational read, write on the clock edge
  logic [31:0] env_mem [0:63] = '{default: 32'h0};
  assign mem_rd = env_mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) env_mem[mem_addr[7:2]] <= mem_wd;

  dmem_port_arbiter #(.DPW(DPW), .STARVE_LIM(LIM)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_rvalid(cpu_rvalid), .o_cpu_err(cpu_err), .o_stall_m(stall_m),
    .i_ld_req(ld_req), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata), .o_ld_gnt(ld_gnt),
    .o_mem_addr(mem_addr), .o_mem_wd(mem_wd), .o_mem_we(mem_we), .i_mem_rd(mem_rd)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] ref_mem [0:63] = '{default: 32'h0};
  int          lost = 0;          // contested cycles lost by preload since its last grant
  logic        e_rvalid = 1'b0, e_err = 1'b0, e_stall = 1'b0, e_ld_gnt = 1'b0;
  logic [31:0] e_rdata = 32'h0;
  logic        obs_gnt, obs_stall, obs_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven; check comb outputs late in the
  // cycle, then registered outputs just after the edge.
  task automatic cycle();
    bit          mis, cpu_ok;
    int          winner;          // 0 none, 1 pipeline, 2 preload
    logic [31:0] ea, ewd, rd_val;
    logic        ewe;
    #3;
    mis    = rst_n && cpu_req && (cpu_addr % 4 != 0);
    cpu_ok = rst_n && cpu_req && !mis;
    winner = 0;
    if (rst_n) begin
      if (cpu_ok && ld_req) winner = (lost >= LIM) ? 2 : 1;
      else if (cpu_ok)      winner = 1;
      else if (ld_req)      winner = 2;
    end
    ea = 0; ewd = 0; ewe = 0;
    if (winner == 1) begin ea = cpu_addr; ewd = cpu_wdata; ewe = cpu_we; end
    if (winner == 2) begin ea = ld_addr;  ewd = ld_wdata;  ewe = 1'b1;   end
    e_stall  = cpu_ok && (winner != 1);
    e_ld_gnt = (winner == 2);
    chk("ld_gnt",   {31'b0, ld_gnt},  {31'b0, e_ld_gnt});
    chk("stall_m",  {31'b0, stall_m}, {31'b0, e_stall});
    chk("mem_we",   {31'b0, mem_we},  {31'b0, ewe});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wd",   mem_wd,   ewd);
    obs_gnt = ld_gnt; obs_stall = stall_m; obs_we = mem_we;
    rd_val = ref_mem[cpu_addr[7:2]];
    @(posedge clk);
    #1;
    if (!rst_n) begin
      lost = 0; e_rvalid = 0; e_rdata = 0; e_err = 0;
    end else begin
      e_rvalid = (winner == 1) && !cpu_we;
      if (e_rvalid) e_rdata = rd_val;
      e_err = mis;
      if (winner == 2) begin
        lost = 0;
        ref_mem[ld_addr[7:2]] = ld_wdata;
      end else begin
        if (winner == 1 && cpu_we) ref_mem[cpu_addr[7:2]] = cpu_wdata;
        if (cpu_ok && ld_req && lost < 15) lost++;
      end
    end
    chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, e_rvalid});
    chk("cpu_rdata",  cpu_rdata, e_rdata);
    chk("cpu_err",    {31'b0, cpu_err},    {31'b0, e_err});
  endtask

  initial begin
    // reset with both requests high
    rst_n = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = 0;
    ld_req = 1; ld_addr = 32'h10; ld_wdata = 32'h1111_1111;
    repeat (2) begin
      cycle();
      chk("rst_gnt", {31'b0, obs_gnt}, 32'd0);
      chk("rst_we",  {31'b0, obs_we},  32'd0);
    end
    chk("rst_rdata", cpu_rdata, 32'h0);

    // preload 0xDEADBEEF to 0x10, then pipeline load returns it
    rst_n = 1; cpu_req = 0; ld_req = 1; ld_addr = 32'h10; ld_wdata = 32'hDEADBEEF;
    cycle();
    chk("pre_gnt", {31'b0, obs_gnt}, 32'd1);
    ld_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    cycle();
    chk("load_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    chk("load_rdata",  cpu_rdata, 32'hDEADBEEF);

    // sustained contention for 10 cycles
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    ld_req = 1; ld_addr = 32'h40; ld_wdata = 32'hA5A5_0000;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("cont_gnt",   {31'b0, obs_gnt},   (i == 4 || i == 9) ? 32'd1 : 32'd0);
      chk("cont_stall", {31'b0, obs_stall}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
    end
    ld_req = 0;
    cycle();   // let the stalled load complete

    // misaligned load with a concurrent preload
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h13;
    ld_req = 1; ld_addr = 32'h44; ld_wdata = 32'h0BAD_F00D;
    cycle();
    chk("mis_gnt",   {31'b0, obs_gnt},   32'd1);
    chk("mis_stall", {31'b0, obs_stall}, 32'd0);
    chk("mis_err",   {31'b0, cpu_err},   32'd1);

    // pipeline store then load back
    ld_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    cycle();
    chk("st_we",     {31'b0, obs_we},     32'd1);
    chk("st_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    cpu_we = 0;
    cycle();
    chk("st_load", cpu_rdata, 32'h12345678);

    // reset right after a granted load
    cpu_addr = 32'h10;
    cycle();
    rst_n = 0;
    cycle();
    chk("rstld_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rstld_rdata",  cpu_rdata, 32'h0);
    rst_n = 1;

    // random traffic obeying the hold rules
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if (!e_stall) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 7) == 0) cpu_addr[1:0] = 2'($urandom_range(1, 3));
        cpu_wdata = $urandom;
      end
      if (!(ld_req && !e_ld_gnt)) begin
        ld_req   = $urandom_range(0, 1) == 1;
        ld_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        ld_wdata = $urandom;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
